registers: RTL and testbench

- Integer register file for the RV32I core: 32 general-purpose registers, each 32 bits (x0..x31).
- Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- x0 is hardwired to zero.
- Sits in the decode/writeback path of the core datapath.

---
 rtl/registers.sv | 55 +++++
 tb/tb_registers.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/registers.sv
// RV32I integer register file: 32 x 32-bit registers, two combinational
// read ports (rs1/rs2) and one synchronous write port (rd). x0 reads as
// zero and ignores writes. Reads do not forward a same-cycle write; the
// pipeline is responsible for forwarding.
module registers #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [$clog2(NREG)-1:0] a1,
    input  logic [$clog2(NREG)-1:0] a2,
    input  logic [$clog2(NREG)-1:0] a3,
    input  logic                    we3,
    input  logic [XLEN-1:0]         wd3,
    output logic [XLEN-1:0]         rd1,
    output logic [XLEN-1:0]         rd2
);

    localparam int AW = $clog2(NREG);

    // Entry 0 exists only to keep indexing simple; it is never written
    // and never read, because x0 is decoded on the read side.
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    logic wr_en;
    assign wr_en = we3 && (a3 != '0);

    // Next-state: update only the addressed register on an enabled write.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[a3] = wd3;
        end
    end

    // Storage: asynchronous active-low clear, otherwise load next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: x0 is a constant, so it is zero even before first reset.
    always_comb begin
        rd1 = (a1 == AW'(0)) ? '0 : regs_q[a1];
        rd2 = (a2 == AW'(0)) ? '0 : regs_q[a2];
    end

endmodule

// File: tb/tb_registers.sv
// Self-checking bench for the RV32I register file. A plain array model
// holds the architectural contents; x0 is modelled as always zero.
module tb_registers;

    logic        clk;
    logic        rst_n;
    logic [4:0]  a1, a2, a3;
    logic        we3;
    logic [31:0] wd3;
    logic [31:0] rd1, rd2;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    registers #(.XLEN(32), .NREG(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a1   (a1),
        .a2   (a2),
        .a3   (a3),
        .we3  (we3),
        .wd3  (wd3),
        .rd1  (rd1),
        .rd2  (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    // One architectural write through the port, with model update.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic en);
        @(negedge clk);
        a3 = addr; wd3 = data; we3 = en;
        @(posedge clk);
        #1;
        we3 = 1'b0;
        if (en && rst_n && addr != 5'd0) model[addr] = data;
    endtask

    task automatic test_powerup();
        a1 = 5'd0; a2 = 5'd0;
        #1;
        checks++;
        if (rd1 !== 32'd0) begin errors++; $display("FAIL powerup_rd1 got=%h exp=%h", rd1, 32'd0); end
        checks++;
        if (rd2 !== 32'd0) begin errors++; $display("FAIL powerup_rd2 got=%h exp=%h", rd2, 32'd0); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 32; i++) begin
            a1 = i[4:0];
            a2 = 5'(31 - i);
            #1;
            checks++;
            if (rd1 !== 32'd0) begin errors++; $display("FAIL reset_sweep_rd1 a=%0d got=%h exp=0", i, rd1); end
            checks++;
            if (rd2 !== 32'd0) begin errors++; $display("FAIL reset_sweep_rd2 a=%0d got=%h exp=0", 31 - i, rd2); end
        end
    endtask

    task automatic test_basic_write();
        do_write(5'd1, 32'd42, 1'b1);
        a1 = 5'd1; a2 = 5'd1;
        #1;
        checks++;
        if (rd1 !== 32'd42) begin errors++; $display("FAIL x1_rd1 got=%h exp=%h", rd1, 32'd42); end
        checks++;
        if (rd2 !== 32'd42) begin errors++; $display("FAIL x1_rd2 got=%h exp=%h", rd2, 32'd42); end
    endtask

    task automatic test_x0_write();
        do_write(5'd0, 32'd122, 1'b1);
        a1 = 5'd0; a2 = 5'd0;
        #1;
        checks++;
        if (rd1 !== 32'd0) begin errors++; $display("FAIL x0_rd1 got=%h exp=0", rd1); end
        checks++;
        if (rd2 !== 32'd0) begin errors++; $display("FAIL x0_rd2 got=%h exp=0", rd2); end
    endtask

    task automatic test_we_gate();
        do_write(5'd5, 32'hDEADBEEF, 1'b0);
        a1 = 5'd5;
        #1;
        checks++;
        if (rd1 !== 32'd0) begin errors++; $display("FAIL we_low_x5 got=%h exp=0", rd1); end
        do_write(5'd5, 32'hDEADBEEF, 1'b1);
        #1;
        checks++;
        if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL we_high_x5 got=%h exp=%h", rd1, 32'hDEADBEEF); end
    endtask

    task automatic test_no_bypass();
        logic [31:0] nv;
        nv = $urandom;
        @(negedge clk);
        a3 = 5'd7; wd3 = nv; we3 = 1'b1;
        a1 = 5'd7; a2 = 5'd7;
        #1;
        checks++;
        if (rd1 !== ref_read(5'd7)) begin errors++; $display("FAIL nobypass_before got=%h exp=%h", rd1, ref_read(5'd7)); end
        @(posedge clk);
        #1;
        we3 = 1'b0;
        model[7] = nv;
        checks++;
        if (rd1 !== nv) begin errors++; $display("FAIL nobypass_after_rd1 got=%h exp=%h", rd1, nv); end
        checks++;
        if (rd2 !== nv) begin errors++; $display("FAIL nobypass_after_rd2 got=%h exp=%h", rd2, nv); end
    endtask

    task automatic test_random();
        logic [4:0]  wa;
        logic [31:0] wv;
        logic        we;
        for (int n = 0; n < 300; n++) begin
            wa = 5'($urandom_range(0, 31));
            wv = $urandom;
            we = ($urandom_range(0, 3) != 0);
            do_write(wa, wv, we);
            a1 = 5'($urandom_range(0, 31));
            a2 = (n % 5 == 0) ? a1 : 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (rd1 !== ref_read(a1)) begin errors++; $display("FAIL rand_rd1 a=%0d got=%h exp=%h", a1, rd1, ref_read(a1)); end
            checks++;
            if (rd2 !== ref_read(a2)) begin errors++; $display("FAIL rand_rd2 a=%0d got=%h exp=%h", a2, rd2, ref_read(a2)); end
        end
    endtask

    task automatic test_async_reset();
        do_write(5'd31, 32'hFFFFFFFF, 1'b1);
        a1 = 5'd31;
        #1;
        checks++;
        if (rd1 !== 32'hFFFFFFFF) begin errors++; $display("FAIL x31_written got=%h exp=%h", rd1, 32'hFFFFFFFF); end
        // Assert reset mid-cycle; value must drop before the next rising edge.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (rd1 !== 32'd0) begin errors++; $display("FAIL async_clear_x31 got=%h exp=0", rd1); end
        // Writes attempted while reset is held must be ignored.
        a3 = 5'd9; wd3 = 32'h12345678; we3 = 1'b1;
        @(posedge clk);
        #1;
        we3 = 1'b0;
        rst_n = 1'b1;
        model_reset();
        a1 = 5'd9; a2 = 5'd1;
        #1;
        checks++;
        if (rd1 !== 32'd0) begin errors++; $display("FAIL write_in_reset_x9 got=%h exp=0", rd1); end
        checks++;
        if (rd2 !== 32'd0) begin errors++; $display("FAIL reset_discard_x1 got=%h exp=0", rd2); end
    endtask

    initial begin
        rst_n = 1'b1;
        we3 = 1'b0; a3 = 5'd0; wd3 = 32'd0;
        a1 = 5'd0; a2 = 5'd0;
        model_reset();
        test_powerup();
        test_reset();
        test_basic_write();
        test_x0_write();
        test_we_gate();
        test_no_bypass();
        test_random();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
